// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decrypt datapath: scheduler FSM states,
// requester tags, block geometry and a lane-count legality helper.
package aes_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The tag doubles as the round-robin pointer value: it names the requester.
  localparam logic TAG_KEY   = 1'b0;
  localparam logic TAG_STATE = 1'b1;

  localparam int BYTES_PER_BLOCK = 16;

  // The bank must split a 16-byte block into whole, equal chunks.
  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
           (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/invsbox_scheduler_if.sv
// Request/response bundle of the shared inverse S-box scheduler.
// master = requesters and result consumer, slave = the scheduler.
interface invsbox_scheduler_if;
  logic         key_valid;
  logic [127:0] key_data;
  logic         key_ready;
  logic         st_valid;
  logic [127:0] st_data;
  logic         st_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_tag;
  logic         out_ready;
  logic         busy;

  modport master (
    output key_valid, key_data, st_valid, st_data, out_ready,
    input  key_ready, st_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  key_valid, key_data, st_valid, st_data, out_ready,
    output key_ready, st_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/invsbox_lane_bank.sv
// Bank of LANES inverse S-box instances; byte gi of din maps to byte gi of dout.
module invsbox_lane_bank #(
  parameter int LANES = 4
) (
  input  logic [LANES*8-1:0] din,
  output logic [LANES*8-1:0] dout
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sbox_LUT_decrypt u_sbox (
      .a (din[gi*8 +: 8]),
      .y (dout[gi*8 +: 8])
    );
  end

endmodule

// File: rtl/sbox_LUT_decrypt.sv
// Combinational AES inverse S-box: inverse affine map followed by the
// multiplicative inverse in GF(2^8) (x^254, with 0 mapping to 0).
module sbox_LUT_decrypt (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc;
    logic [7:0] t;
    acc = '0;
    t   = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) acc = acc ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128, which is the inverse for x != 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] pre;

  // Undo the affine map (rotations 1, 3, 6 plus constant 0x05), then invert.
  always_comb begin
    pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    y   = gf_inv(pre);
  end

endmodule

// File: rtl/invsbox_scheduler.sv
// Shares one inverse S-box bank between the key-schedule and state paths:
// round-robin grant, NCHUNK passes over an in-place work buffer, then the
// result is held until the consumer takes it.
module invsbox_scheduler
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  invsbox_scheduler_if.slave bus
);

  localparam int NCHUNK = BYTES_PER_BLOCK / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LW     = LANES * 8;

  if (!lanes_legal(LANES)) begin : g_lanes_check
    $error("invsbox_scheduler: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic            prio_reg;
  logic            tag_reg;
  logic [127:0]    work_reg;
  logic            grant_key;
  logic            grant_st;
  logic            last_chunk;
  logic [LW-1:0]   bank_in;
  logic [LW-1:0]   bank_out;

  // Round-robin arbitration; grants only in IDLE and never while reset is held.
  always_comb begin
    grant_key = 1'b0;
    grant_st  = 1'b0;
    if (state_reg == IDLE && !reset) begin
      grant_key = bus.key_valid && (!bus.st_valid || prio_reg == TAG_KEY);
      grant_st  = bus.st_valid && (!bus.key_valid || prio_reg == TAG_STATE);
    end
  end

  assign last_chunk = (cnt_reg == CW'(NCHUNK - 1));

  // Select the chunk of the work buffer addressed by the counter.
  always_comb begin
    bank_in = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_reg == CW'(i)) bank_in = work_reg[i*LW +: LW];
    end
  end

  invsbox_lane_bank #(.LANES(LANES)) u_bank (
    .din  (bank_in),
    .dout (bank_out)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_key || grant_st) state_next = BUSY;
      BUSY:    if (last_chunk)            state_next = DONE;
      DONE:    if (bus.out_ready)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: readies are the grants, result fields come from registers.
  always_comb begin
    bus.key_ready = grant_key;
    bus.st_ready  = grant_st;
    bus.out_valid = (state_reg == DONE);
    bus.busy      = (state_reg != IDLE);
    bus.out_data  = work_reg;
    bus.out_tag   = tag_reg;
  end

  // Capture on grant, then rewrite one chunk per BUSY cycle in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_reg <= '0;
      tag_reg  <= TAG_KEY;
      cnt_reg  <= '0;
      prio_reg <= TAG_KEY;
    end else if (grant_key) begin
      work_reg <= bus.key_data;
      tag_reg  <= TAG_KEY;
      cnt_reg  <= '0;
      prio_reg <= TAG_STATE;
    end else if (grant_st) begin
      work_reg <= bus.st_data;
      tag_reg  <= TAG_STATE;
      cnt_reg  <= '0;
      prio_reg <= TAG_KEY;
    end else if (state_reg == BUSY) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (cnt_reg == CW'(i)) work_reg[i*LW +: LW] <= bank_out;
      end
      cnt_reg <= last_chunk ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_invsbox_scheduler.sv
// Self-checking bench for invsbox_scheduler: directed scenarios plus a
// randomized phase, all compared against a table-driven inverse S-box model.
module tb_invsbox_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  invsbox_scheduler_if bus();
  invsbox_scheduler_if bus1();
  invsbox_scheduler_if bus16();

  invsbox_scheduler #(.LANES(4))  u_dut   (.clk(clk), .reset(rst), .bus(bus));
  invsbox_scheduler #(.LANES(1))  u_dut1  (.clk(clk), .reset(rst), .bus(bus1));
  invsbox_scheduler #(.LANES(16)) u_dut16 (.clk(clk), .reset(rst), .bus(bus16));

  int checks = 0;
  int errors = 0;

  logic [7:0] inv_tab [256];
  int         tb_prio;   // 0: key preferred next, 1: state preferred next
  bit         synced;    // 1: already at the IDLE negedge where a grant is visible

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from the generator-3 walk over GF(2^8), then invert the table.
  task automatic build_model();
    logic [7:0] p, q, x;
    logic [7:0] fwd [256];
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      fwd[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model_block(input logic [127:0] d);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = inv_tab[d[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One grant-to-handoff transaction on the LANES=4 instance.
  task automatic serve_one(input bit refill, input int hold, input string name,
                           output logic [127:0] got_data, output logic got_tag);
    bit           exp_key, found, leak, stable;
    logic [127:0] din, exp_out;
    int           k;
    got_data = '0;
    got_tag  = 1'b0;
    exp_key  = bus.key_valid && (!bus.st_valid || tb_prio == 0);
    din      = exp_key ? bus.key_data : bus.st_data;
    exp_out  = model_block(din);
    if (!synced) @(negedge clk);
    synced = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.key_ready || bus.st_ready) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_eq({name, "_grant_seen"}, found, 1'b1);
    if (!found) return;
    check_eq({name, "_key_ready"}, bus.key_ready, exp_key);
    check_eq({name, "_st_ready"}, bus.st_ready, !exp_key);
    check_eq({name, "_busy_at_grant"}, bus.busy, 1'b0);
    tb_prio = exp_key ? 1 : 0;
    @(posedge clk); #1;
    if (exp_key) begin
      if (refill) bus.key_data = rand128(); else bus.key_valid = 1'b0;
    end else begin
      if (refill) bus.st_data = rand128(); else bus.st_valid = 1'b0;
    end
    k = 0; found = 1'b0; leak = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      k++;
      if (bus.key_ready || bus.st_ready) leak = 1'b1;
      if (bus.out_valid) begin found = 1'b1; break; end
    end
    check_eq({name, "_out_valid_seen"}, found, 1'b1);
    if (!found) return;
    check_eq({name, "_latency"}, k, 5);
    check_eq({name, "_ready_while_busy"}, leak, 1'b0);
    check_eq({name, "_data"}, bus.out_data, exp_out);
    check_eq({name, "_tag"}, bus.out_tag, exp_key ? 1'b0 : 1'b1);
    got_data = bus.out_data;
    got_tag  = bus.out_tag;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== exp_out || bus.out_tag !== got_tag ||
          bus.key_ready || bus.st_ready) stable = 1'b0;
    end
    if (hold > 0) check_eq({name, "_hold_stable"}, stable, 1'b1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq({name, "_handoff_no_ready"}, bus.key_ready || bus.st_ready, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq({name, "_idle_after"}, {bus.busy, bus.out_valid}, 2'b00);
    $display("txn %s tag=%0d data=%h", name, got_tag, got_data);
  endtask

  // Grant one requester, then assert reset during the second BUSY cycle.
  task automatic reset_mid(input bit use_key, input string name);
    @(posedge clk); #1;
    if (use_key) begin bus.key_valid = 1'b1; bus.key_data = rand128(); end
    else         begin bus.st_valid  = 1'b1; bus.st_data  = rand128(); end
    @(negedge clk);
    check_eq({name, "_grant"}, use_key ? bus.key_ready : bus.st_ready, 1'b1);
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.st_valid  = 1'b0;
    @(posedge clk); #1;
    check_eq({name, "_busy_before"}, bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq({name, "_rst_outs"},
             {bus.out_valid, bus.out_tag, bus.busy, bus.key_ready, bus.st_ready}, 5'b0);
    check_eq({name, "_rst_data"}, bus.out_data, 128'd0);
    $display("txn %s reset mid-busy", name);
    @(posedge clk); #1;
    rst = 1'b0;
    tb_prio = 0;
    synced = 1'b0;
  endtask

  logic [127:0] d2, exp2, gd;
  logic         gt;
  logic [2:0]   order;
  int           l1, l16;
  bit           f1, f16;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    bus.key_valid = 0; bus.key_data = '0; bus.st_valid = 0; bus.st_data = '0; bus.out_ready = 0;
    bus1.key_valid = 0; bus1.key_data = '0; bus1.st_valid = 0; bus1.st_data = '0; bus1.out_ready = 0;
    bus16.key_valid = 0; bus16.key_data = '0; bus16.st_valid = 0; bus16.st_data = '0; bus16.out_ready = 0;
    tb_prio = 0;
    synced  = 1'b0;

    // Reset state, with a key request already pending.
    bus.key_valid = 1'b1;
    bus.key_data  = {16{8'h63}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_data", bus.out_data, 128'd0);
    check_eq("rst_out_tag", bus.out_tag, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_key_ready", bus.key_ready, 1'b0);
    check_eq("rst_st_ready", bus.st_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single key request of 0x63 bytes.
    serve_one(1'b0, 0, "t1", gd, gt);
    check_eq("t1_const", gd, 128'd0);

    // 2: byte mapping on the state path.
    d2 = {16{8'h63}};
    d2[7:0] = 8'h7C; d2[47:40] = 8'h16; d2[127:120] = 8'h00;
    exp2 = '0;
    exp2[7:0] = 8'h01; exp2[47:40] = 8'hFF; exp2[127:120] = 8'h52;
    @(posedge clk); #1;
    bus.st_valid = 1'b1;
    bus.st_data  = d2;
    synced = 1'b0;
    serve_one(1'b0, 0, "t2", gd, gt);
    check_eq("t2_const", gd, exp2);
    check_eq("t2_tag_const", gt, 1'b1);

    // 3: both requesters held for three blocks.
    @(posedge clk); #1;
    bus.key_valid = 1'b1; bus.key_data = rand128();
    bus.st_valid  = 1'b1; bus.st_data  = rand128();
    synced = 1'b0;
    serve_one(1'b1, 0, "t3a", gd, gt); order[0] = gt;
    serve_one(1'b1, 0, "t3b", gd, gt); order[1] = gt;
    serve_one(1'b0, 0, "t3c", gd, gt); order[2] = gt;
    check_eq("t3_order", order, 3'b010);
    serve_one(1'b0, 0, "t3d", gd, gt);

    // 4: backpressure for 10 cycles in DONE.
    @(posedge clk); #1;
    bus.key_valid = 1'b1; bus.key_data = rand128();
    synced = 1'b0;
    serve_one(1'b0, 10, "t4", gd, gt);

    // Randomized traffic.
    for (int r = 0; r < 12; r++) begin
      if (!bus.key_valid && !bus.st_valid) begin
        @(posedge clk); #1;
        case ($urandom_range(0, 2))
          0:       begin bus.key_valid = 1'b1; bus.key_data = rand128(); end
          1:       begin bus.st_valid  = 1'b1; bus.st_data  = rand128(); end
          default: begin
            bus.key_valid = 1'b1; bus.key_data = rand128();
            bus.st_valid  = 1'b1; bus.st_data  = rand128();
          end
        endcase
        synced = 1'b0;
      end
      serve_one(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                $sformatf("rnd%0d", r), gd, gt);
    end
    for (int r = 0; r < 2; r++) begin
      if (bus.key_valid || bus.st_valid)
        serve_one(1'b0, 0, $sformatf("drain%0d", r), gd, gt);
    end

    // 5: reset mid-BUSY, then both requesters: key must win.
    reset_mid(1'b0, "t5a");
    reset_mid(1'b1, "t5b");
    bus.key_valid = 1'b1; bus.key_data = rand128();
    bus.st_valid  = 1'b1; bus.st_data  = rand128();
    serve_one(1'b0, 0, "t5c", gd, gt);
    check_eq("t5c_key_first", gt, 1'b0);
    serve_one(1'b0, 0, "t5d", gd, gt);

    // 6: LANES=1 and LANES=16 with the byte-mapping block.
    @(posedge clk); #1;
    bus1.st_valid = 1'b1;  bus1.st_data = d2;
    bus16.st_valid = 1'b1; bus16.st_data = d2;
    @(negedge clk);
    check_eq("t6_l1_grant", bus1.st_ready, 1'b1);
    check_eq("t6_l16_grant", bus16.st_ready, 1'b1);
    @(posedge clk); #1;
    bus1.st_valid = 1'b0;
    bus16.st_valid = 1'b0;
    f1 = 1'b0; f16 = 1'b0; l1 = -1; l16 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!f1 && bus1.out_valid)   begin f1 = 1'b1;  l1 = c;  end
      if (!f16 && bus16.out_valid) begin f16 = 1'b1; l16 = c; end
      if (f1 && f16) break;
    end
    check_eq("t6_l1_latency", l1, 17);
    check_eq("t6_l16_latency", l16, 2);
    check_eq("t6_l1_data", bus1.out_data, exp2);
    check_eq("t6_l16_data", bus16.out_data, exp2);
    check_eq("t6_tags", {bus1.out_tag, bus16.out_tag}, 2'b11);
    $display("txn t6 l1_lat=%0d l16_lat=%0d", l1, l16);
    @(posedge clk); #1;
    bus1.out_ready = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0; bus16.out_ready = 1'b0;
    @(negedge clk);
    check_eq("t6_idle", {bus1.busy, bus16.busy}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/invsbox_scheduler.md
Name: invsbox_scheduler

Overview:
Shares a bank of LANES inverse S-box lookups (sbox_LUT_decrypt) between two 128-bit requesters.
- Requester 0: key path (reverse key schedule).
- Requester 1: state path (InvSubBytes).
Arbitrates round-robin, then sequences the 16 bytes through the bank over 16/LANES cycles. Holds the result until the consumer accepts it.
Sits between the decrypt round controller and the key/state registers, replacing 16+16 parallel lookups.

Parameters:
LANES, 4, inverse S-box instances in the bank; legal values 1, 2, 4, 8, 16.
NCHUNK, 16/LANES, derived (localparam); cycles per block.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
key_valid  input  1  key requester has a block.
key_data  input  128  key block; byte b = bits [8b+7:8b] = element [b%4][b/4] of the 4x4 byte array.
key_ready  output  1  key block accepted this cycle.
st_valid  input  1  state requester has a block.
st_data  input  128  state block, same packing.
st_ready  output  1  state block accepted this cycle.
out_valid  output  1  result available.
out_data  output  128  InvSbox applied bytewise, same packing.
out_tag  output  1  0 = key result, 1 = state result.
out_ready  input  1  consumer accepts the result.
busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (asynchronous, active-high) values:
  - out_valid=0, out_data=0, out_tag=0, busy=0.
  - key_ready=0, st_ready=0.
  - FSM=IDLE, chunk counter=0, priority pointer=0 (key first).
- FSM IDLE:
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the one the priority pointer selects; the pointer then flips to the other requester.
  - A single-requester grant also sets the pointer to the other requester.
  - The granted *_ready is high combinationally in this cycle only. The data is captured into the work buffer, the tag is latched, counter=0, and the FSM goes to BUSY.
  - If no valid is high, stay in IDLE.
- FSM BUSY:
  - Each cycle, bytes counter*LANES .. counter*LANES+LANES-1 of the work buffer go through the bank and are written back in place; counter increments.
  - After the chunk with counter=NCHUNK-1, go to DONE.
- FSM DONE:
  - out_valid=1; out_data = work buffer; out_tag = latched tag.
  - When out_ready=1: go to IDLE; out_valid drops the next cycle.
  - out_data and out_tag hold until then.
- Ready outputs: key_ready and st_ready are never high outside IDLE. No new block is accepted in the cycle that DONE hands off; that cycle goes to IDLE first.
- Latency: grant at cycle T → out_valid at T+1+NCHUNK. With LANES=4, out_valid is at T+5. Throughput is one block per NCHUNK+2 cycles, with out_ready held high.
- Valids are sticky: a requester holds valid and data until its ready. A request dropped while not granted is simply not served.
- No bytes are reordered. out_data byte b = InvSbox(in byte b) for all b.
- Reset mid-BUSY or mid-DONE: everything returns to reset values immediately and the partial result is discarded.
- The counter width is max(1, clog2(NCHUNK)). For LANES=16 the block runs a single BUSY cycle.

Decomposition:
- Shared package aes_dec_pkg holds:
  - FSM state enum {IDLE, BUSY, DONE};
  - tag constants TAG_KEY=0, TAG_STATE=1;
  - BYTES_PER_BLOCK=16;
  - a helper function that checks LANES legality, to be used in an elaboration-time assertion.
- One sub-module, invsbox_lane_bank: LANES instances of sbox_LUT_decrypt with a LANES*8-bit input and output, purely combinational.
- Arbiter, counter and buffer stay in invsbox_scheduler.

Test Plan:
1. Single key request. key_data with all bytes 0x63, LANES=4 → key_ready pulse at T; out_valid at T+5; out_data all 0x00; out_tag=0.
2. Byte mapping. st_data byte0=0x7C, byte5=0x16, byte15=0x00, others 0x63 → out byte0=0x01, byte5=0xFF, byte15=0x52, others 0x00; out_tag=1.
3. Simultaneous requests held for three blocks → grant order key, state, key. Each out_tag matches its block, and ready never goes high for a requester while busy=1.
4. Backpressure. out_ready low for 10 cycles in DONE → out_valid and out_data stable; no *_ready pulses; on the out_ready pulse, IDLE the next cycle.
5. Reset asserted at the 2nd BUSY cycle → all outputs are 0 in the same cycle. A request after deassertion gets correct output and the key has priority.
6. Parameter sweep LANES ∈ {1, 16} with scenario 2 data → out_valid at T+17 and T+2 respectively, with identical out_data.
